coreriscv_axi4_tl_acquire_arbiter_2: RTL



---
 rtl/coreriscv_axi4_tl_pkg.sv | 34 +++
 rtl/coreriscv_axi4_rr_pick2.sv | 20 ++
 rtl/coreriscv_axi4_tl_acquire_arbiter_2.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/coreriscv_axi4_tl_pkg.sv
// Shared field widths, constants, acquire bundle and state encoding for
// the TileLink acquire arbiter.
package coreriscv_axi4_tl_pkg;

    localparam int ADDR_BLOCK_W = 26;
    localparam int CXID_W       = 2;
    localparam int BEAT_W       = 3;
    localparam int UNION_W      = 12;
    localparam int DATA_W       = 64;
    localparam int ATYPE_W      = 3;

    localparam logic [ATYPE_W-1:0] ACQ_PUT_BLOCK = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        BURST
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_BLOCK_W-1:0] addr_block;
        logic [CXID_W-1:0]       cxid;
        logic [BEAT_W-1:0]       addr_beat;
        logic                    builtin;
        logic [ATYPE_W-1:0]      a_type;
        logic [UNION_W-1:0]      un;
        logic [DATA_W-1:0]       data;
    } acq_t;

    function automatic logic is_put_block(input acq_t a);
        return a.builtin && (a.a_type == ACQ_PUT_BLOCK);
    endfunction

endpackage

// File: rtl/coreriscv_axi4_rr_pick2.sv
// Two-way winner pick. Round-robin on `last` when
// CORERISCV_AXI4_TL_ARB_RR_EN is defined, else requester 0 has fixed priority.
module coreriscv_axi4_rr_pick2 (
    input  logic [1:0] valid,
`ifdef CORERISCV_AXI4_TL_ARB_RR_EN
    input  logic       last,
`endif
    output logic       winner,
    output logic       any_valid
);

    assign any_valid = |valid;

`ifdef CORERISCV_AXI4_TL_ARB_RR_EN
    assign winner = (&valid) ? ~last : valid[1];
`else
    assign winner = ~valid[0] & valid[1];
`endif

endmodule

// File: rtl/coreriscv_axi4_tl_acquire_arbiter_2.sv
// Two-requester TileLink acquire arbiter with PutBlock locking and grant
// routing by client_xact_id LSB. Round-robin via CORERISCV_AXI4_TL_ARB_RR_EN.
module coreriscv_axi4_tl_acquire_arbiter_2
    import coreriscv_axi4_tl_pkg::*;
#(
    parameter int NBEATS = 8,
    parameter int BEAT_W = 3
) (
    input  logic        clk,
    input  logic        reset,

    output logic        io_in_0_acquire_ready,
    input  logic        io_in_0_acquire_valid,
    input  logic [25:0] io_in_0_acquire_bits_addr_block,
    input  logic [1:0]  io_in_0_acquire_bits_client_xact_id,
    input  logic [2:0]  io_in_0_acquire_bits_addr_beat,
    input  logic        io_in_0_acquire_bits_is_builtin_type,
    input  logic [2:0]  io_in_0_acquire_bits_a_type,
    input  logic [11:0] io_in_0_acquire_bits_union,
    input  logic [63:0] io_in_0_acquire_bits_data,
    input  logic        io_in_0_grant_ready,
    output logic        io_in_0_grant_valid,
    output logic [2:0]  io_in_0_grant_bits_addr_beat,
    output logic [1:0]  io_in_0_grant_bits_client_xact_id,
    output logic        io_in_0_grant_bits_manager_xact_id,
    output logic        io_in_0_grant_bits_is_builtin_type,
    output logic [3:0]  io_in_0_grant_bits_g_type,
    output logic [63:0] io_in_0_grant_bits_data,

    output logic        io_in_1_acquire_ready,
    input  logic        io_in_1_acquire_valid,
    input  logic [25:0] io_in_1_acquire_bits_addr_block,
    input  logic [1:0]  io_in_1_acquire_bits_client_xact_id,
    input  logic [2:0]  io_in_1_acquire_bits_addr_beat,
    input  logic        io_in_1_acquire_bits_is_builtin_type,
    input  logic [2:0]  io_in_1_acquire_bits_a_type,
    input  logic [11:0] io_in_1_acquire_bits_union,
    input  logic [63:0] io_in_1_acquire_bits_data,
    input  logic        io_in_1_grant_ready,
    output logic        io_in_1_grant_valid,
    output logic [2:0]  io_in_1_grant_bits_addr_beat,
    output logic [1:0]  io_in_1_grant_bits_client_xact_id,
    output logic        io_in_1_grant_bits_manager_xact_id,
    output logic        io_in_1_grant_bits_is_builtin_type,
    output logic [3:0]  io_in_1_grant_bits_g_type,
    output logic [63:0] io_in_1_grant_bits_data,

    input  logic        io_out_acquire_ready,
    output logic        io_out_acquire_valid,
    output logic [25:0] io_out_acquire_bits_addr_block,
    output logic [2:0]  io_out_acquire_bits_client_xact_id,
    output logic [2:0]  io_out_acquire_bits_addr_beat,
    output logic        io_out_acquire_bits_is_builtin_type,
    output logic [2:0]  io_out_acquire_bits_a_type,
    output logic [11:0] io_out_acquire_bits_union,
    output logic [63:0] io_out_acquire_bits_data,

    output logic        io_out_grant_ready,
    input  logic        io_out_grant_valid,
    input  logic [2:0]  io_out_grant_bits_addr_beat,
    input  logic [2:0]  io_out_grant_bits_client_xact_id,
    input  logic        io_out_grant_bits_manager_xact_id,
    input  logic        io_out_grant_bits_is_builtin_type,
    input  logic [3:0]  io_out_grant_bits_g_type,
    input  logic [63:0] io_out_grant_bits_data
);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NBEATS - 1);

    acq_t       in_acq [2];
    acq_t       acq;
    logic [1:0] in_v;
    arb_state_e state;
    logic       sel;
    logic [BEAT_W-1:0] beat_cnt;
    logic       pick_win;
    logic       pick_any;
    logic       win;
    logic       mux_sel;
    logic       fire;
    logic       tgt;

    assign in_acq[0] = {
        io_in_0_acquire_bits_addr_block,
        io_in_0_acquire_bits_client_xact_id,
        io_in_0_acquire_bits_addr_beat,
        io_in_0_acquire_bits_is_builtin_type,
        io_in_0_acquire_bits_a_type,
        io_in_0_acquire_bits_union,
        io_in_0_acquire_bits_data
    };
    assign in_acq[1] = {
        io_in_1_acquire_bits_addr_block,
        io_in_1_acquire_bits_client_xact_id,
        io_in_1_acquire_bits_addr_beat,
        io_in_1_acquire_bits_is_builtin_type,
        io_in_1_acquire_bits_a_type,
        io_in_1_acquire_bits_union,
        io_in_1_acquire_bits_data
    };
    assign in_v = {io_in_1_acquire_valid, io_in_0_acquire_valid};

`ifdef CORERISCV_AXI4_TL_ARB_RR_EN
    logic last;

    coreriscv_axi4_rr_pick2 u_pick (
        .valid     (in_v),
        .last      (last),
        .winner    (pick_win),
        .any_valid (pick_any)
    );
`else
    coreriscv_axi4_rr_pick2 u_pick (
        .valid     (in_v),
        .winner    (pick_win),
        .any_valid (pick_any)
    );
`endif

    // Once held or bursting, the registered sel owns the output.
    assign win     = (state == IDLE) ? pick_win : sel;
    assign mux_sel = reset ? 1'b0 : win;
    assign acq     = in_acq[mux_sel];

    assign io_out_acquire_valid  = ~reset & in_v[win];
    assign fire = io_out_acquire_valid & io_out_acquire_ready;
    assign io_in_0_acquire_ready = ~reset & io_out_acquire_ready & ~win;
    assign io_in_1_acquire_ready = ~reset & io_out_acquire_ready & win;

    assign io_out_acquire_bits_addr_block      = acq.addr_block;
    assign io_out_acquire_bits_client_xact_id  = {acq.cxid, mux_sel};
    assign io_out_acquire_bits_addr_beat       = acq.addr_beat;
    assign io_out_acquire_bits_is_builtin_type = acq.builtin;
    assign io_out_acquire_bits_a_type          = acq.a_type;
    assign io_out_acquire_bits_union           = acq.un;
    assign io_out_acquire_bits_data            = acq.data;

    assign tgt = io_out_grant_bits_client_xact_id[0];
    assign io_in_0_grant_valid = ~reset & io_out_grant_valid & ~tgt;
    assign io_in_1_grant_valid = ~reset & io_out_grant_valid & tgt;
    assign io_out_grant_ready  = ~reset &
        (tgt ? io_in_1_grant_ready : io_in_0_grant_ready);

    assign io_in_0_grant_bits_addr_beat       = io_out_grant_bits_addr_beat;
    assign io_in_0_grant_bits_client_xact_id  = io_out_grant_bits_client_xact_id[2:1];
    assign io_in_0_grant_bits_manager_xact_id = io_out_grant_bits_manager_xact_id;
    assign io_in_0_grant_bits_is_builtin_type = io_out_grant_bits_is_builtin_type;
    assign io_in_0_grant_bits_g_type          = io_out_grant_bits_g_type;
    assign io_in_0_grant_bits_data            = io_out_grant_bits_data;
    assign io_in_1_grant_bits_addr_beat       = io_out_grant_bits_addr_beat;
    assign io_in_1_grant_bits_client_xact_id  = io_out_grant_bits_client_xact_id[2:1];
    assign io_in_1_grant_bits_manager_xact_id = io_out_grant_bits_manager_xact_id;
    assign io_in_1_grant_bits_is_builtin_type = io_out_grant_bits_is_builtin_type;
    assign io_in_1_grant_bits_g_type          = io_out_grant_bits_g_type;
    assign io_in_1_grant_bits_data            = io_out_grant_bits_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= 1'b0;
            beat_cnt <= '0;
`ifdef CORERISCV_AXI4_TL_ARB_RR_EN
            last     <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (fire) begin
`ifdef CORERISCV_AXI4_TL_ARB_RR_EN
                        last <= win;
`endif
                        if (is_put_block(acq)) begin
                            sel      <= win;
                            beat_cnt <= BEAT_W'(1);
                            state    <= BURST;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (state == IDLE && pick_any) begin
                        sel   <= win;
                        state <= HOLD;
                    end
                end
                BURST: begin
                    if (fire) begin
                        if (beat_cnt == BEAT_LAST) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
